// File: rtl/uart_kernel_nios2_cpu_debug_vji_pkg.sv
// rtl/uart_kernel_nios2_cpu_debug_vji_pkg.sv - shared types and constants for the virtual-JTAG debug master
//
// Purpose: the virtual-JTAG state enum, the debug IR codes and the default
// DR width shared by the master top and its bench.
// Ports: none (package).
// Optional feature macro used by importers: VJI_MASTER_IR_CACHE_EN.
package uart_kernel_nios2_cpu_debug_vji_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI
  } vji_state_t;

  localparam int IR_OCIMEM    = 0;
  localparam int IR_TRACEMEM  = 1;
  localparam int IR_BREAK     = 2;
  localparam int IR_TRACECTRL = 3;

  localparam int DR_W_DEFAULT = 38;

  // Strobe vector {uir, cdr, sdr, udr, rti}; IDLE and RTI both drive rti.
  function automatic logic [4:0] state_strobes(input vji_state_t s);
    logic [4:0] v;
    v = 5'b00000;
    case (s)
      UIR:     v = 5'b10000;
      CDR:     v = 5'b01000;
      SDR:     v = 5'b00100;
      UDR:     v = 5'b00010;
      default: v = 5'b00001;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/uart_kernel_nios2_cpu_debug_master_tckgen.sv
// rtl/uart_kernel_nios2_cpu_debug_master_tckgen.sv - vji_tck divider with rise/fall pulses
//
// Purpose: divides clk into vji_tck (TCK_DIV clks low, TCK_DIV clks high,
// starting low) while run is high. tck_rise / tck_fall are high during the
// clk cycle whose closing edge moves vji_tck, so logic clocked by clk acts
// on exactly the edge where tck changes.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   clear               synchronous restart of the divider (command accepted)
//   run                 divider advances while high (transaction in flight)
//   tck                 generated test clock
//   tck_rise, tck_fall  one-clk pulses preceding the tck edges
module uart_kernel_nios2_cpu_debug_master_tckgen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  generate
    if (TCK_DIV < 1) begin : g_bad_div
      $error("TCK_DIV must be at least 1");
    end
  endgenerate

  localparam int CNT_W = ($clog2(2 * TCK_DIV) < 1) ? 1 : $clog2(2 * TCK_DIV);
  localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(2 * TCK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tck_rise = run && (cnt == RISE_AT);
  assign tck_fall = run && (cnt == FALL_AT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (run) begin
      cnt <= tck_fall ? '0 : cnt + 1'b1;
      if (tck_rise) begin
        tck <= 1'b1;
      end else if (tck_fall) begin
        tck <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_kernel_nios2_cpu_debug_master_vji.sv
// rtl/uart_kernel_nios2_cpu_debug_master_vji.sv - host-side virtual-JTAG initiator for the Nios II debug slave
//
// Purpose: on a command, walks UIR -> CDR -> SDR (DR_W slots) -> UDR -> RTI,
// one tck period per slot, shifting cmd_dr out on vji_tdi (LSB first) and
// collecting the slave's word from vji_tdo, then pulses rsp_valid.
// Optional feature macro: VJI_MASTER_IR_CACHE_EN - skip UIR when the command
// IR matches the IR already loaded into the slave.
// Ports:
//   clk, reset_n                  system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_ir / cmd_dr payload
//   rsp_valid                     one-clk completion pulse; rsp_dr / rsp_ir result
//   vji_tck, vji_tdi, vji_tdo     generated test clock and serial data
//   vji_ir_in, vji_ir_out         IR presented to / status from the slave
//   vji_uir..vji_rti              one-hot virtual state strobes
module uart_kernel_nios2_cpu_debug_master_vji
  import uart_kernel_nios2_cpu_debug_vji_pkg::*;
#(
  parameter int DR_W    = DR_W_DEFAULT,
  parameter int IR_W    = 2,
  parameter int TCK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  output logic [DR_W-1:0] rsp_dr,
  output logic [IR_W-1:0] rsp_ir,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int SLOT_W = (DR_W > 1) ? $clog2(DR_W) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DR_W - 1);

  vji_state_t        state, state_next;
  logic [4:0]        strobes, strobe_next;
  logic              accept, skip_uir, tck_rise, tck_fall;
  logic [DR_W-1:0]   dr_lat, tx, rx;
  logic [SLOT_W-1:0] slot;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign vji_tdi   = tx[0];
  assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = strobes;

`ifdef VJI_MASTER_IR_CACHE_EN
  // vji_ir_in already holds the last IR shifted into the slave; this bit
  // records that it is meaningful (false until the first UIR after reset).
  logic ir_cached;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_cached <= 1'b0;
    end else if (accept) begin
      ir_cached <= 1'b1;
    end
  end
  assign skip_uir = ir_cached && (cmd_ir == vji_ir_in);
`else
  assign skip_uir = 1'b0;
`endif

  uart_kernel_nios2_cpu_debug_master_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .run      (state != IDLE),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  // State register; strobes are registered from the next state so they
  // switch on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      strobes <= 5'b00001;
    end else begin
      state   <= state_next;
      strobes <= strobe_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = skip_uir ? CDR : UIR;
      UIR:  if (tck_fall) state_next = CDR;
      CDR:  if (tck_fall) state_next = SDR;
      SDR:  if (tck_fall && (slot == LAST_SLOT)) state_next = UDR;
      UDR:  if (tck_fall) state_next = RTI;
      RTI:  if (tck_fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    strobe_next = state_strobes(state_next);
  end

  // Shift path. tx is loaded on the CDR->SDR fall so bit 0 is on tdi before
  // the first SDR rise; a zero is shifted in so tdi rests low afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dr_lat    <= '0;
      tx        <= '0;
      rx        <= '0;
      slot      <= '0;
      vji_ir_in <= '0;
      rsp_ir    <= '0;
      rsp_dr    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        dr_lat <= cmd_dr;
        if (!skip_uir) vji_ir_in <= cmd_ir;
      end
      if ((state == CDR) && tck_fall) begin
        tx <= dr_lat;
      end else if ((state == SDR) && tck_fall) begin
        tx   <= {1'b0, tx[DR_W-1:1]};
        slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      end
      if ((state == SDR) && tck_rise) begin
        rx <= {vji_tdo, rx[DR_W-1:1]};
      end
      if ((state == UDR) && tck_fall) begin
        rsp_ir <= vji_ir_out;
      end
      if ((state == RTI) && tck_fall) begin
        rsp_dr    <= rx;
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_kernel_nios2_cpu_debug_master_vji.sv
// tb/tb_uart_kernel_nios2_cpu_debug_master_vji.sv - self-checking bench for the virtual-JTAG debug master
module tb_uart_kernel_nios2_cpu_debug_master_vji;

  localparam int DR_W    = 38;
  localparam int IR_W    = 2;
  localparam int TCK_DIV = 4;
`ifdef VJI_MASTER_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_dr;
  logic            rsp_valid;
  logic [DR_W-1:0] rsp_dr;
  logic [IR_W-1:0] rsp_ir;
  logic            vji_tck, vji_tdi, vji_tdo;
  logic [IR_W-1:0] vji_ir_in, vji_ir_out;
  logic            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  uart_kernel_nios2_cpu_debug_master_vji #(
    .DR_W (DR_W), .IR_W (IR_W), .TCK_DIV (TCK_DIV)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_ir (cmd_ir), .cmd_dr (cmd_dr),
    .rsp_valid (rsp_valid), .rsp_dr (rsp_dr), .rsp_ir (rsp_ir),
    .vji_tck (vji_tck), .vji_tdi (vji_tdi), .vji_tdo (vji_tdo),
    .vji_ir_in (vji_ir_in), .vji_ir_out (vji_ir_out),
    .vji_uir (vji_uir), .vji_cdr (vji_cdr), .vji_sdr (vji_sdr),
    .vji_udr (vji_udr), .vji_rti (vji_rti)
  );

  always #5 clk = ~clk;

  // Slave model: captures its word in CDR, shifts on tck rise in SDR.
  logic [DR_W-1:0] sr = '0;
  logic [DR_W-1:0] slave_capture = '0;
  assign vji_tdo = sr[0];
  always @(posedge vji_tck) begin
    if (vji_cdr) sr = slave_capture;
    else if (vji_sdr) sr = {vji_tdi, sr[DR_W-1:1]};
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor, sampled on the falling clk edge.
  logic prev_tck = 1'b0, prev_tdi = 1'b0;
  int   onehot_bad = 0, tdi_bad = 0, sdr_clks = 0;
  bit   uir_seen = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) != 1) onehot_bad++;
      if ((vji_tdi !== prev_tdi) && !(prev_tck && !vji_tck)) tdi_bad++;
      if (vji_sdr) sdr_clks++;
      if (vji_uir) uir_seen = 1'b1;
    end
    prev_tck = vji_tck;
    prev_tdi = vji_tdi;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model state.
  bit              cache_valid = 1'b0;
  logic [IR_W-1:0] cache_ir = '0;
  bit              exp_uir;
  int              exp_lat;
  logic [DR_W-1:0] exp_rsp, exp_sr;
  logic [IR_W-1:0] exp_ir, exp_iro;

  task automatic check_reset_vals(input string tag);
    check(tag, 64'({cmd_ready, rsp_valid, rsp_dr, rsp_ir, vji_tck, vji_tdi, vji_ir_in,
                    vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}),
               64'({1'b1, 1'b0, 38'd0, 2'd0, 1'b0, 1'b0, 2'd0, 5'b00001}));
  endtask

  task automatic start_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           input logic [DR_W-1:0] cap, input logic [IR_W-1:0] iro);
    logic [63:0] junk;
    exp_uir = !(CACHE && cache_valid && (ir == cache_ir));
    exp_lat = (DR_W + 4) * 2 * TCK_DIV - (exp_uir ? 0 : 2 * TCK_DIV);
    exp_rsp = cap;
    exp_sr  = dr;
    exp_ir  = ir;
    exp_iro = iro;
    slave_capture = cap;
    vji_ir_out    = iro;
    onehot_bad = 0; tdi_bad = 0; sdr_clks = 0; uir_seen = 1'b0;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    check("ready_before_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    junk = {$urandom, $urandom};
    cmd_valid = 1'b0; cmd_ir = ~ir; cmd_dr = junk[DR_W-1:0];
    cache_valid = 1'b1; cache_ir = ir;
    check("first_slot_uir_cdr", 64'({vji_uir, vji_cdr}), exp_uir ? 64'd2 : 64'd1);
    check("busy_after_accept", 64'(cmd_ready), 64'd0);
    check("rsp_pulse_ended", 64'(rsp_valid), 64'd0);
  endtask

  task automatic finish_cmd(input bit poke);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 150) begin
        cmd_valid = 1'b1; cmd_ir = ~exp_ir; cmd_dr = ~exp_sr;
      end
      if (poke && n == 152) check("busy_ignored_ready", 64'(cmd_ready), 64'd0);
      if (poke && n == 154) cmd_valid = 1'b0;
      if (rsp_valid) got = 1'b1;
    end
    check("rsp_seen", 64'(got), 64'd1);
    check("latency", 64'(n), 64'(exp_lat));
    check("rsp_dr", 64'(rsp_dr), 64'(exp_rsp));
    check("rsp_ir", 64'(rsp_ir), 64'(exp_iro));
    check("slave_sr", 64'(sr), 64'(exp_sr));
    check("vji_ir_in", 64'(vji_ir_in), 64'(exp_ir));
    check("ready_in_rsp_cycle", 64'({cmd_ready, vji_tck, vji_rti}), 64'b101);
    check("uir_seen", 64'(uir_seen), 64'(exp_uir));
    check("sdr_clks", 64'(sdr_clks), 64'(DR_W * 2 * TCK_DIV));
    check("strobes_onehot", 64'(onehot_bad), 64'd0);
    check("tdi_on_fall_only", 64'(tdi_bad), 64'd0);
  endtask

  initial begin
    logic [63:0] r1, r2;
    bit reached, bad_rsp;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; vji_ir_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_values");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle_after_reset");

    // Directed transaction, with a command poked mid-SDR that must be ignored.
    start_cmd(2'd2, 38'h2A_AAAA_AAAA, 38'h3_1234_5678, 2'd1);
    finish_cmd(1'b1);

    // Random back-to-back transactions, each issued in the rsp_valid cycle.
    for (int i = 0; i < 4; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      start_cmd(2'($urandom_range(0, 3)), r1[DR_W-1:0], r2[DR_W-1:0], 2'($urandom_range(0, 3)));
      finish_cmd(1'b0);
    end

    // Same IR twice in a row.
    for (int i = 0; i < 2; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      start_cmd(2'd1, r1[DR_W-1:0], r2[DR_W-1:0], 2'd3);
      finish_cmd(1'b0);
    end

    // Reset in the middle of shift slot 17.
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    start_cmd(2'd1, r1[DR_W-1:0], r2[DR_W-1:0], 2'd0);
    reached = 1'b0;
    for (int k = 0; k < 1000 && !reached; k++) begin
      @(posedge clk); #1;
      if (sdr_clks >= 17 * 2 * TCK_DIV + TCK_DIV) reached = 1'b1;
    end
    check("reached_slot17", 64'(reached), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_sdr");
    bad_rsp = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad_rsp = 1'b1;
    end
    reset_n = 1'b1;
    cache_valid = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad_rsp = 1'b1;
    end
    check("no_rsp_after_reset", 64'(bad_rsp), 64'd0);
    check_reset_vals("idle_after_mid_reset");

    // Following transaction must be clean; same IR as before reset.
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    start_cmd(2'd1, r1[DR_W-1:0], r2[DR_W-1:0], 2'd2);
    finish_cmd(1'b0);
    @(posedge clk); #1;
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_kernel_nios2_cpu_debug_master_vji.md
Name: uart_kernel_nios2_cpu_debug_master_vji

Overview:
- Virtual-JTAG host-side initiator: the opposite end of the Nios II debug slave's sld_virtual_jtag_basic link.
- Generates vji_tck from clk and sequences the virtual-JTAG states UIR, CDR, SDR, UDR and RTI.
- Shifts one DR_W-bit debug word into the slave over tdi while capturing the slave's word from tdo.
- Used for on-chip self-test and simulation of the debug slave in place of the JTAG hub; driven by a simple command/response handshake.

Parameters:
- DR_W, 38: debug data-register width in bits (matches the slave's sr/jdo).
- IR_W, 2: virtual IR width.
- TCK_DIV, 4: clk cycles per vji_tck half-period. Must be >= 1; elaboration error if 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when IDLE.
- cmd_ir  in  IR_W  virtual IR to load (0 ocimem, 1 tracemem, 2 break, 3 tracectrl).
- cmd_dr  in  DR_W  word to shift into the slave, LSB first.
- rsp_valid  out  1  one-cycle pulse: transaction done.
- rsp_dr  out  DR_W  word captured from vji_tdo.
- rsp_ir  out  IR_W  vji_ir_out sampled in UDR.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_W  IR presented to the slave.
- vji_ir_out  in  IR_W  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  one-hot virtual state strobes.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, vji_rti=1, all other strobes 0. State is IDLE.
- Handshake and idle:
  - A command is accepted on the clk edge where cmd_valid && cmd_ready.
  - cmd_valid while busy is ignored; no queueing.
  - cmd_dr and cmd_ir are latched at acceptance and need not be held afterwards.
- TCK generation:
  - vji_tck is held low in IDLE.
  - On acceptance the divider clears; vji_tck rises after TCK_DIV clks and falls after 2*TCK_DIV clks, then repeats.
  - One state slot is one tck period, i.e. 2*TCK_DIV clks.
- State machine:
  - IDLE -> UIR -> CDR -> SDR (held DR_W slots) -> UDR -> RTI -> IDLE.
  - State advances only on the clk edge where vji_tck falls.
  - Strobes are registered and one-hot with the state: vji_rti=1 in both IDLE and RTI.
- vji_ir_in: loaded with cmd_ir on entry to UIR and held until the next UIR.
- Shift path:
  - vji_tdi = tx[0]; tx is launched and shifted right on each tck fall within SDR.
  - vji_tdo is sampled on each tck rise within SDR: rx <= {vji_tdo, rx[DR_W-1:1]}.
  - The shift-slot counter runs 0..DR_W-1 and exits SDR on the fall after slot DR_W-1; it is never left at DR_W.
- Outputs on completion:
  - In UDR, rsp_ir <= vji_ir_out.
  - On RTI -> IDLE: rsp_dr <= rx, rsp_valid=1 for exactly one clk, cmd_ready=1 in the same cycle.
  - rsp_dr and rsp_ir hold until the next completion.
- Latency: accept to rsp_valid = (DR_W+4)*2*TCK_DIV clks; 336 with defaults.
- Back-to-back: a command accepted in the rsp_valid cycle is legal; UIR starts on the next clk.
- Reset mid-transaction: immediate return to reset values; no rsp_valid is emitted; the partially shifted word is discarded.

Optional Feature:
- Macro: VJI_MASTER_IR_CACHE_EN.
- Defined:
  - A cached last-IR register plus a valid bit, cleared by reset, are added.
  - If cmd_ir equals the cached IR, UIR is skipped: IDLE -> CDR, and latency drops by 2*TCK_DIV.
  - The first command after reset always performs UIR.
- Undefined: every transaction passes through UIR.

Decomposition:
- Package uart_kernel_nios2_cpu_debug_vji_pkg holds:
  - the state enum (IDLE, UIR, CDR, SDR, UDR, RTI);
  - IR code constants IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3;
  - DR_W_DEFAULT=38.
- Sub-module uart_kernel_nios2_cpu_debug_master_tckgen:
  - divider that outputs vji_tck plus one-clk tck_rise/tck_fall pulses, with a synchronous clear on acceptance.
  - The FSM and shift registers stay in the top module.

Test Plan:
- Reset values: hold reset_n=0 -> all outputs at reset values (vji_rti=1, cmd_ready=1, vji_tck=0).
- Single transaction:
  - Setup: bench slave model with sr preloaded 38'h3_1234_5678, shifting {tdi, sr[37:1]} on tck rise during sdr.
  - Stimulus: cmd_ir=2, cmd_dr=38'h2A_AAAA_AAAA.
  - Required response: rsp_dr=38'h3_1234_5678; model sr=38'h2A_AAAA_AAAA after UDR; rsp_valid exactly 336 clks after accept; vji_ir_in=2.
- Strobe checks:
  - Strobes one-hot on every clk of the transaction.
  - vji_sdr high for exactly 38 tck periods.
  - vji_tdi changes only in clks where tck falls.
- Busy and back-to-back:
  - Second cmd_valid asserted mid-SDR -> ignored.
  - Command re-issued in the rsp_valid cycle -> accepted, UIR next clk.
- Reset mid-transaction: reset_n pulsed low at shift slot 17 -> outputs at reset values, no rsp_valid; the following transaction is correct.
- Under VJI_MASTER_IR_CACHE_EN:
  - Two commands with ir=1 -> second has no vji_uir pulse and latency 328.
  - First command after reset shows a vji_uir pulse.
